// File: rtl/gcd_seq_pkg.sv
// Shared state encoding, sizing constants and the operand pair table for the GCD operand sequencer.
package gcd_seq_pkg;

    localparam int GCD_SEQ_DEPTH   = 8;
    localparam int GCD_SEQ_IDX_W   = 3;
    localparam int GCD_SEQ_TIMER_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP_A,
        S_PRESS_A,
        S_REL_A,
        S_SETUP_B,
        S_PRESS_B,
        S_REL_B,
        S_WAIT_RES,
        S_CAPTURE,
        S_SETTLE,
        S_DONE
    } gcd_seq_state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expected;
    } gcd_seq_pair_t;

    // Expected values use the calculator's magnitude view of operands with bit 7 set.
    localparam gcd_seq_pair_t GCD_SEQ_TABLE [GCD_SEQ_DEPTH] = '{
        '{8'd48,  8'd18, 8'd6},
        '{8'd17,  8'd5,  8'd1},
        '{8'd100, 8'd75, 8'd25},
        '{8'd0,   8'd9,  8'd9},
        '{8'hF6,  8'd4,  8'd2},
        '{8'hFF,  8'd7,  8'd1},
        '{8'h80,  8'd64, 8'd64},
        '{8'd12,  8'd12, 8'd12}
    };

endpackage

// File: rtl/gcd_seq_timer.sv
// Loadable down-counter with a zero flag; one instance times every GAP, PRESS and TIMEOUT interval.
module gcd_seq_timer
    import gcd_seq_pkg::*;
#(
    parameter int WIDTH = GCD_SEQ_TIMER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Autonomous two-press operand-entry initiator driving the GCD calculator from a constant pair table.
// Build option: define GCD_SEQ_SELFCHECK_EN to compare each captured result against the table.
module gcd_operand_sequencer
    import gcd_seq_pkg::*;
#(
    parameter int NUM_PAIRS      = 8,
    parameter int PRESS_CYCLES   = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [7:0]                   result,
    output logic [7:0]                   num_out,
    output logic                         btn_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_PAIRS)-1:0] pair_idx,
    output logic [7:0]                   last_result,
    output logic [7:0]                   pass_count,
    output logic                         fail,
    output logic                         timeout
);

    localparam int IDX_W = $clog2(NUM_PAIRS);
    localparam int TW    = GCD_SEQ_TIMER_W;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_PAIRS - 1);
    localparam logic [TW-1:0]    GAP_LOAD     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]    PRESS_LOAD   = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0]    TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    gcd_seq_state_t           r_state;
    logic [IDX_W-1:0]         r_pairIdx;
    logic [7:0]               r_numOut;
    logic [7:0]               r_lastResult;
    logic [7:0]               r_passCount;
    logic                     r_btnOut;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_timeout;
    logic [GCD_SEQ_IDX_W-1:0] w_tblIdx;
    logic [GCD_SEQ_IDX_W-1:0] w_nextIdx;
    logic                     w_timerLoad;
    logic [TW-1:0]            w_timerValue;
    logic                     w_timerZero;

    assign w_tblIdx  = GCD_SEQ_IDX_W'(r_pairIdx);
    assign w_nextIdx = w_tblIdx + 1'b1;

`ifdef GCD_SEQ_SELFCHECK_EN
    logic       r_fail;
    logic [7:0] w_expected;
    assign w_expected = GCD_SEQ_TABLE[w_tblIdx].expected;
    assign fail       = r_fail;
`else
    assign fail       = 1'b0;
`endif

    gcd_seq_timer #(.WIDTH(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_timerLoad),
        .i_value (w_timerValue),
        .o_zero  (w_timerZero)
    );

    // The timer is reloaded on the edge that leaves a state, with the length of the state being entered.
    always_comb begin
        w_timerLoad  = 1'b0;
        w_timerValue = GAP_LOAD;
        case (r_state)
            S_IDLE, S_DONE:       w_timerLoad = start;
            S_SETUP_A, S_SETUP_B: begin
                w_timerLoad  = w_timerZero;
                w_timerValue = PRESS_LOAD;
            end
            S_PRESS_A, S_REL_A,
            S_PRESS_B, S_SETTLE:  w_timerLoad = w_timerZero;
            S_REL_B: begin
                w_timerLoad  = w_timerZero;
                w_timerValue = TIMEOUT_LOAD;
            end
            S_CAPTURE:            w_timerLoad = 1'b1;
            default:              w_timerLoad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pairIdx    <= '0;
            r_numOut     <= 8'd0;
            r_lastResult <= 8'd0;
            r_passCount  <= 8'd0;
            r_btnOut     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef GCD_SEQ_SELFCHECK_EN
            r_fail       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_SETUP_A;
                        r_pairIdx    <= '0;
                        r_numOut     <= GCD_SEQ_TABLE[0].a;
                        r_lastResult <= 8'd0;
                        r_passCount  <= 8'd0;
                        r_timeout    <= 1'b0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
`ifdef GCD_SEQ_SELFCHECK_EN
                        r_fail       <= 1'b0;
`endif
                    end
                end
                S_SETUP_A: if (w_timerZero) begin
                    r_state  <= S_PRESS_A;
                    r_btnOut <= 1'b1;
                end
                S_PRESS_A: if (w_timerZero) begin
                    r_state  <= S_REL_A;
                    r_btnOut <= 1'b0;
                end
                S_REL_A: if (w_timerZero) begin
                    r_state  <= S_SETUP_B;
                    r_numOut <= GCD_SEQ_TABLE[w_tblIdx].b;
                end
                S_SETUP_B: if (w_timerZero) begin
                    r_state  <= S_PRESS_B;
                    r_btnOut <= 1'b1;
                end
                S_PRESS_B: if (w_timerZero) begin
                    r_state  <= S_REL_B;
                    r_btnOut <= 1'b0;
                end
                S_REL_B: if (w_timerZero) begin
                    r_state <= S_WAIT_RES;
                end
                // An expired wait aborts the whole run; the calculator needs its own reset afterwards.
                S_WAIT_RES: begin
                    if (result != 8'd0) begin
                        r_state <= S_CAPTURE;
                    end else if (w_timerZero) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_state      <= S_SETTLE;
                    r_lastResult <= result;
`ifdef GCD_SEQ_SELFCHECK_EN
                    if (result == w_expected) begin
                        if (r_passCount != 8'hFF) r_passCount <= r_passCount + 8'd1;
                    end else begin
                        r_fail <= 1'b1;
                    end
`else
                    if (r_passCount != 8'hFF) r_passCount <= r_passCount + 8'd1;
`endif
                end
                S_SETTLE: if (w_timerZero) begin
                    if (r_pairIdx == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= S_SETUP_A;
                        r_pairIdx <= r_pairIdx + 1'b1;
                        r_numOut  <= GCD_SEQ_TABLE[w_nextIdx].a;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_btnOut <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign num_out     = r_numOut;
    assign btn_out     = r_btnOut;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pair_idx    = r_pairIdx;
    assign last_result = r_lastResult;
    assign pass_count  = r_passCount;
    assign timeout     = r_timeout;

endmodule

// File: doc/gcd_operand_sequencer.md
# gcd_operand_sequencer

Autonomous initiator for the two-press operand-entry protocol of the board-level GCD calculator. It replaces the human at the switches and key. It walks a constant table of operand pairs and, for each pair, presents operand A and pulses the entry button. It then presents operand B and pulses again, waits for the calculator's nonzero result on its LED bus, and records and checks that result. It sits between the calculator and the board top: the top inverts `btn_out` onto the calculator's active-low key and wires the LED bus back to `result`.

## Interface
Parameters:
- `NUM_PAIRS`, 8: number of table entries to run; must be ≤ the package table depth (8).
- `PRESS_CYCLES`, 4: cycles `btn_out` is held high per press; ≥ 2.
- `GAP_CYCLES`, 4: setup, release and settle interval in cycles; ≥ 2.
- `TIMEOUT_CYCLES`, 1024: maximum wait for a nonzero result.

Ports:
- `clk` in 1: single clock; the calculator uses the same clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: level; sampled only in IDLE and DONE.
- `result` in 8: calculator LED bus.
- `num_out` out 8: operand presented on the switch lines.
- `btn_out` out 1: entry press, active-high.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `pair_idx` out $clog2(NUM_PAIRS): index of the current pair.
- `last_result` out 8: most recently captured result.
- `pass_count` out 8: number of pairs whose result matched the table.
- `fail` out 1: sticky; set on any mismatch.
- `timeout` out 1: sticky; set when a result wait expired.

## Operation
- States and transitions:
  - IDLE → SETUP_A on `start`.
  - SETUP_A drives `num_out`=A for GAP_CYCLES → PRESS_A.
  - PRESS_A holds `btn_out`=1 for PRESS_CYCLES → REL_A.
  - REL_A holds `btn_out`=0 for GAP_CYCLES → SETUP_B.
  - SETUP_B, PRESS_B and REL_B behave the same as the A states, using operand B.
  - REL_B → WAIT_RES.
  - WAIT_RES → CAPTURE.
  - CAPTURE → SETTLE.
  - SETTLE → SETUP_A for the next pair, or → DONE after pair NUM_PAIRS-1.
- `num_out` is stable from SETUP entry through the end of REL. One rising edge of `btn_out` occurs per operand.
- WAIT_RES: a down-counter starts at TIMEOUT_CYCLES.
  - `result != 0` → CAPTURE.
  - Counter reaching 0 → set `timeout`, go directly to DONE (abort). After an abort the calculator can only be recovered by its own reset.
- CAPTURE: one cycle. `last_result` ← `result`; self-check applies here (see Configuration).
- SETTLE: GAP_CYCLES of idle, so the calculator has returned to first-operand entry before the next press.
- DONE: `start` high restarts at pair 0. The restart clears `pass_count`, `fail`, `timeout` and `last_result`.
- `start` outside IDLE/DONE is ignored.
- Operands are raw 8-bit patterns. The calculator takes the magnitude of values with bit 7 set; the expected values in the table already account for that (0x80 has magnitude 128).
- The table never contains the pair (0,0). The calculator never produces a nonzero result for it, so that pair would only time out.
- `pass_count` saturates at 255.

## Timing
- Reset (async assert, synchronous deassert via the clock edge) puts every output at 0, and the state at IDLE.
- Reset mid-run drops `btn_out` immediately.
- Press rising edge: SETUP + GAP_CYCLES cycles after `num_out` changes.
- Cycles from `start` to the PRESS_B falling edge: 3·GAP_CYCLES + 2·PRESS_CYCLES + 1 (IDLE exit).
- CAPTURE occurs on the cycle after `result` is first seen nonzero.
- `done` asserts on the cycle after the last SETTLE cycle.

## Configuration
- `GCD_SEQ_SELFCHECK_EN` defined: CAPTURE compares `result` against the table's expected value.
  - Match increments `pass_count`.
  - Mismatch sets `fail`.
- Not defined: no comparison.
  - `pass_count` counts completed pairs.
  - `fail` ties to 0.
  - The expected column is unused.

## Structure
- Package `gcd_seq_pkg` holds:
  - the state enum;
  - `GCD_SEQ_DEPTH` = 8;
  - the constant pair table `{a, b, expected}` with these entries: (48,18,6), (17,5,1), (100,75,25), (0,9,9), (0xF6,4,2), (0xFF,7,1), (0x80,64,64), (12,12,12).
- One sub-module, `gcd_seq_timer`: a loadable down-counter with a zero flag. It serves the GAP, PRESS and TIMEOUT intervals.

## Test plan
- Sequencer paired with the real calculator, self-check on, `start` pulse → 8 presses of A and 8 of B; `done`=1, `pass_count`=8, `fail`=0, `last_result`=12.
- Behavioural responder that returns 7 for pair 0 (expected 6) → `fail`=1, `pass_count`=7 at done.
- Responder that never drives `result` nonzero, TIMEOUT_CYCLES=16 → `timeout`=1, `done`=1, `pair_idx`=0, and no further presses.
- `rst_n` low during PRESS_B → `btn_out`=0 and `num_out`=0 in the same cycle; IDLE after release; a rerun then completes with `pass_count`=8.
- `start` held high throughout → exactly one run per DONE→restart. Counters are cleared at restart; `start` is ignored while `busy`.
- Self-check macro undefined, mismatching responder → `fail`=0, `pass_count`=8.
